// File: rtl/reg_bank_reader.sv
// 32 x 32-bit register bank with one write port and two registered read ports.
// Register 0 always reads zero. The stack-pointer register is seeded on reset.
module reg_bank_reader #(
   parameter int unsigned  SP_INDEX       = 29,
   parameter logic [31:0]  SP_RESET_VALUE = 32'd227
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        reg_write,
   input  logic [4:0]  write_reg,
   input  logic [31:0] write_data,
   input  logic        rd_en,
   input  logic [4:0]  read_reg_1,
   input  logic [4:0]  read_reg_2,
   output logic [31:0] read_data_1,
   output logic [31:0] read_data_2,
   output logic        rd_valid
);

   logic [31:0] regs [32];
   logic        write_ok;
   logic [31:0] value_1;
   logic [31:0] value_2;

   assign write_ok = reg_write && (write_reg != 5'd0);

   // Forward a same-cycle write so a read never sees the stale value.
   always_comb begin
      value_1 = regs[read_reg_1];
      if (read_reg_1 == 5'd0) begin
         value_1 = '0;
      end else if (write_ok && (write_reg == read_reg_1)) begin
         value_1 = write_data;
      end
   end

   always_comb begin
      value_2 = regs[read_reg_2];
      if (read_reg_2 == 5'd0) begin
         value_2 = '0;
      end else if (write_ok && (write_reg == read_reg_2)) begin
         value_2 = write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) begin
            regs[5'(i)] <= (i == int'(SP_INDEX)) ? SP_RESET_VALUE : 32'd0;
         end
      end else if (write_ok) begin
         regs[write_reg] <= write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         read_data_1 <= '0;
         read_data_2 <= '0;
         rd_valid    <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en) begin
            read_data_1 <= value_1;
            read_data_2 <= value_2;
         end
      end
   end

endmodule
